// File: rtl/cpx_multiply_arbiter.sv
// Round-robin arbiter sharing one pipelined cpx_multiply among NUM_REQ requesters.
// Optional macro CPX_ARB_STATS_EN adds a 32-bit wrapping handshake counter output, grant_count.
module cpx_multiply_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int XI_BITS      = 16,
  parameter int YI_BITS      = 16,
  parameter int OUT_BITS     = 33,
  parameter int MULT_LATENCY = 2,
  parameter int ID_BITS      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arb_en,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*XI_BITS-1:0] req_xi,
  input  logic [NUM_REQ*XI_BITS-1:0] req_xq,
  input  logic [NUM_REQ*YI_BITS-1:0] req_yi,
  input  logic [NUM_REQ*YI_BITS-1:0] req_yq,
  output logic [XI_BITS-1:0]         mul_xi,
  output logic [XI_BITS-1:0]         mul_xq,
  output logic [YI_BITS-1:0]         mul_yi,
  output logic [YI_BITS-1:0]         mul_yq,
  input  logic [OUT_BITS-1:0]        mul_i_out,
  input  logic [OUT_BITS-1:0]        mul_q_out,
  output logic                       out_valid,
  output logic [ID_BITS-1:0]         out_id,
  output logic [OUT_BITS-1:0]        out_i,
  output logic [OUT_BITS-1:0]        out_q,
  output logic                       busy
`ifdef CPX_ARB_STATS_EN
  ,
  output logic [31:0]                grant_count
`endif
);

  logic [ID_BITS-1:0]                    last_grant_r;
  logic                                  hi_found_s, lo_found_s, handshake_s;
  logic [ID_BITS-1:0]                    hi_idx_s, lo_idx_s, grant_idx_s;
  int                                    sel_s;
  logic [MULT_LATENCY-1:0]               tag_valid_r;
  logic [MULT_LATENCY-1:0][ID_BITS-1:0]  tag_id_r;

  // Rotating priority search: the lowest valid index above last_grant wins, else the lowest at or below it.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      hi_found_s = (req_valid[k] && (k > int'(last_grant_r))) ? 1'b1 : hi_found_s;
      hi_idx_s   = (req_valid[k] && (k > int'(last_grant_r))) ? ID_BITS'(k) : hi_idx_s;
      lo_found_s = (req_valid[k] && (k <= int'(last_grant_r))) ? 1'b1 : lo_found_s;
      lo_idx_s   = (req_valid[k] && (k <= int'(last_grant_r))) ? ID_BITS'(k) : lo_idx_s;
    end
    if (hi_found_s) begin
      grant_idx_s = hi_idx_s;
    end else begin
      grant_idx_s = lo_idx_s;
    end
    handshake_s = (hi_found_s | lo_found_s) & arb_en & rst_n;
    sel_s       = int'(grant_idx_s);
    if (handshake_s) begin
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      req_ready = '0;
    end
  end

  // Operand capture and pointer update on a handshake; operands hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_xi       <= '0;
      mul_xq       <= '0;
      mul_yi       <= '0;
      mul_yq       <= '0;
      last_grant_r <= ID_BITS'(NUM_REQ - 1);
    end else if (handshake_s) begin
      mul_xi       <= req_xi[sel_s*XI_BITS +: XI_BITS];
      mul_xq       <= req_xq[sel_s*XI_BITS +: XI_BITS];
      mul_yi       <= req_yi[sel_s*YI_BITS +: YI_BITS];
      mul_yq       <= req_yq[sel_s*YI_BITS +: YI_BITS];
      last_grant_r <= grant_idx_s;
    end
  end

  // Tag pipeline tracks {valid, id} alongside the multiplier stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_r <= '0;
      tag_id_r    <= '0;
    end else begin
      tag_valid_r[0] <= handshake_s;
      tag_id_r[0]    <= grant_idx_s;
      for (int s = 1; s < MULT_LATENCY; s++) begin
        tag_valid_r[s] <= tag_valid_r[s-1];
        tag_id_r[s]    <= tag_id_r[s-1];
      end
    end
  end

  // Result register: products are captured bit-exact when the last tag stage is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_i     <= '0;
      out_q     <= '0;
    end else if (tag_valid_r[MULT_LATENCY-1]) begin
      out_valid <= 1'b1;
      out_id    <= tag_id_r[MULT_LATENCY-1];
      out_i     <= mul_i_out;
      out_q     <= mul_q_out;
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign busy = (|tag_valid_r) | out_valid;

`ifdef CPX_ARB_STATS_EN
  // Handshake counter; wraps from all-ones to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_count <= 32'd0;
    end else if (handshake_s) begin
      grant_count <= grant_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpx_multiply_arbiter.sv
// Scoreboard bench for cpx_multiply_arbiter with a one-register stand-in multiplier (latency 2).
module tb_cpx_multiply_arbiter;

  typedef struct {
    logic [1:0]  id;
    logic [32:0] i;
    logic [32:0] q;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arb_en;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_xi, req_xq, req_yi, req_yq;
  logic [15:0] mul_xi, mul_xq, mul_yi, mul_yq;
  logic signed [32:0] p_i = '0;
  logic signed [32:0] p_q = '0;
  logic        out_valid;
  logic [1:0]  out_id;
  logic [32:0] out_i, out_q;
  logic        busy;
`ifdef CPX_ARB_STATS_EN
  logic [31:0] grant_count;
`endif

  logic [15:0] op_xi[4], op_xq[4], op_yi[4], op_yq[4];
  logic [32:0] tab_i[4], tab_q[4];
  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          issued = 0;

  cpx_multiply_arbiter dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_xi(req_xi), .req_xq(req_xq), .req_yi(req_yi), .req_yq(req_yq),
    .mul_xi(mul_xi), .mul_xq(mul_xq), .mul_yi(mul_yi), .mul_yq(mul_yq),
    .mul_i_out(p_i), .mul_q_out(p_q),
    .out_valid(out_valid), .out_id(out_id), .out_i(out_i), .out_q(out_q),
    .busy(busy)
`ifdef CPX_ARB_STATS_EN
    , .grant_count(grant_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [32:0] sx(input logic [15:0] v);
    return {{17{v[15]}}, v};
  endfunction

  // Stand-in multiplier: one internal register after the arbiter's operand registers.
  always @(posedge clk) begin
    p_i <= sx(mul_xi) * sx(mul_yi) - sx(mul_xq) * sx(mul_yq);
    p_q <= sx(mul_xi) * sx(mul_yq) + sx(mul_xq) * sx(mul_yi);
  end

  always_comb begin
    req_xi = '0; req_xq = '0; req_yi = '0; req_yq = '0;
    for (int k = 0; k < 4; k++) begin
      req_xi[k*16 +: 16] = op_xi[k];
      req_xq[k*16 +: 16] = op_xq[k];
      req_yi[k*16 +: 16] = op_yi[k];
      req_yq[k*16 +: 16] = op_yq[k];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented result is matched against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_result: got id=%0d i=%0h with nothing expected", out_id, out_i);
      end else begin
        e = sb.pop_front();
        check("out_id", {62'd0, out_id}, {62'd0, e.id});
        check("out_i", {31'd0, out_i}, {31'd0, e.i});
        check("out_q", {31'd0, out_q}, {31'd0, e.q});
        check("latency", 64'(cyc - e.cyc), 64'd3);
      end
    end
  end

  task automatic drive(input logic [3:0] v, input logic en, input logic [3:0] exp_rdy,
                       input logic push, input int exp_busy);
    exp_t e;
    req_valid = v;
    arb_en    = en;
    @(negedge clk);
    check("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
    if (exp_busy >= 0) check("busy", {63'd0, busy}, {63'd0, exp_busy[0]});
    if (exp_rdy != 4'b0000) begin
      issued++;
      if (push) begin
        e.id = 2'd0;
        for (int k = 0; k < 4; k++) if (exp_rdy[k]) e.id = 2'(k);
        e.i   = tab_i[e.id];
        e.q   = tab_q[e.id];
        e.cyc = cyc;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // requester k: x=(k+1,1), y=(2,k) -> i=k+2, q=k*k+k+2
    for (int k = 0; k < 4; k++) begin
      op_xi[k] = 16'(k + 1); op_xq[k] = 16'd1;
      op_yi[k] = 16'd2;      op_yq[k] = 16'(k);
    end
    tab_i[0] = 33'd2; tab_i[1] = 33'd3; tab_i[2] = 33'd4; tab_i[3] = 33'd5;
    tab_q[0] = 33'd2; tab_q[1] = 33'd4; tab_q[2] = 33'd8; tab_q[3] = 33'd14;

    rst_n = 1'b0; arb_en = 1'b1; req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {60'd0, req_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_mul_xi", {48'd0, mul_xi}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round-robin with all requesters valid
    for (int c = 0; c < 8; c++) drive(4'b1111, 1'b1, 4'b0001 << (c % 4), 1'b1, -1);
    repeat (3) drive(4'b0000, 1'b1, 4'b0000, 1'b1, -1);
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 0);

    // Single operation: requester 2, x=(3,4), y=(5,-2) -> (23,14)
    op_xi[2] = 16'd3; op_xq[2] = 16'd4; op_yi[2] = 16'd5; op_yq[2] = 16'hFFFE;
    tab_i[2] = 33'd23; tab_q[2] = 33'd14;
    drive(4'b0100, 1'b1, 4'b0100, 1'b1, 0);
    repeat (3) drive(4'b0000, 1'b1, 4'b0000, 1'b1, 1);
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 0);

    // Enable gating with requesters 0 and 1
    drive(4'b0011, 1'b1, 4'b0001, 1'b1, -1);
    drive(4'b0011, 1'b1, 4'b0010, 1'b1, -1);
    repeat (3) drive(4'b0011, 1'b0, 4'b0000, 1'b1, 1);
    drive(4'b0011, 1'b1, 4'b0001, 1'b1, -1);
    drive(4'b0011, 1'b1, 4'b0010, 1'b1, -1);
    repeat (3) drive(4'b0000, 1'b1, 4'b0000, 1'b1, -1);
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 0);

    // Extreme operands on requester 3
    op_xi[3] = 16'h8000; op_xq[3] = 16'h8000; op_yi[3] = 16'h8000; op_yq[3] = 16'h8000;
    tab_i[3] = 33'd0; tab_q[3] = 33'h0_8000_0000;
    drive(4'b1000, 1'b1, 4'b1000, 1'b1, -1);
    repeat (3) drive(4'b0000, 1'b1, 4'b0000, 1'b1, -1);
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 0);
`ifdef CPX_ARB_STATS_EN
    check("grant_count", {32'd0, grant_count}, 64'(issued));
`endif

    // Reset one cycle after a handshake: the result must be discarded
    drive(4'b0010, 1'b1, 4'b0010, 1'b0, -1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_req_ready", {60'd0, req_ready}, 64'd0);
    check("mid_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_busy", {63'd0, busy}, 64'd0);
    check("mid_mul_xi", {48'd0, mul_xi}, 64'd0);
    check("mid_out_q", {31'd0, out_q}, 64'd0);
    check("mid_out_id", {62'd0, out_id}, 64'd0);
`ifdef CPX_ARB_STATS_EN
    check("mid_grant_count", {32'd0, grant_count}, 64'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) drive(4'b0000, 1'b1, 4'b0000, 1'b1, 0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpx_multiply_arbiter.md
# cpx_multiply_arbiter

Round-robin arbiter that shares one pipelined `cpx_multiply` instance among `NUM_REQ` requesters in the CAF datapath. It accepts at most one complex operand pair per cycle over valid/ready handshakes. It drives the multiplier's operand inputs and carries each requester's ID through a tag pipeline matched to the multiplier latency. Each returned product is presented with the ID of the requester that issued it.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `XI_BITS`, 16: width of each x component (signed).
- `YI_BITS`, 16: width of each y component (signed).
- `OUT_BITS`, 33: width of each product component (signed). Must equal the multiplier's `i_out_bits`/`q_out_bits`.
- `MULT_LATENCY`, 2: number of cycles from multiplier inputs to multiplier outputs, ≥1.
- `ID_BITS`, 2: ID width, ≥ clog2(`NUM_REQ`).

Ports:
- `clk`, in, 1: the single clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `arb_en`, in, 1: grant enable. When low, no new grants are issued and in-flight results drain.
- `req_valid`, in, `NUM_REQ`: per-requester operand valid.
- `req_ready`, out, `NUM_REQ`: per-requester grant. One-hot or zero.
- `req_xi`, `req_xq`, in, `NUM_REQ*XI_BITS`: packed operand x. Requester k occupies slice k.
- `req_yi`, `req_yq`, in, `NUM_REQ*YI_BITS`: packed operand y.
- `mul_xi`, `mul_xq`, out, `XI_BITS`: multiplier x operand (registered).
- `mul_yi`, `mul_yq`, out, `YI_BITS`: multiplier y operand (registered).
- `mul_i_out`, `mul_q_out`, in, `OUT_BITS`: multiplier products.
- `out_valid`, out, 1: result strobe. One cycle per result.
- `out_id`, out, `ID_BITS`: ID of the requester that issued the result.
- `out_i`, `out_q`, out, `OUT_BITS`: registered product.
- `busy`, out, 1: high while any issued operation has not yet produced `out_valid`.

## Operation
- **Grant computation (combinational):**
  - Search `req_valid` starting at `last_grant+1` mod `NUM_REQ`.
  - The first set bit wins, and the matching `req_ready` bit is set, provided `arb_en` is high.
  - `req_ready` depends on `req_valid` and is never asserted for a non-valid requester.
- **Handshake:** a handshake occurs in a cycle where `req_valid[k] & req_ready[k]`. On that edge:
  - `mul_*` registers load slice k of the packed operands.
  - The tag pipeline stage 0 loads {1, k}.
  - `last_grant` is updated to k.
- **Idle cycles:** in a cycle with no handshake, `mul_*` hold their previous values and tag stage 0 loads valid=0.
- **Tag pipeline:** `MULT_LATENCY` stages of {valid, id}. When the last stage is valid on an edge:
  - `out_i`/`out_q` are loaded from `mul_i_out`/`mul_q_out`.
  - `out_id` is loaded from the stage id.
  - `out_valid` is set to 1.
  - Otherwise `out_valid` is 0 and the data outputs hold.
- **Results:** no output backpressure. Results emerge in issue order, exactly one per handshake, and the arbiter never reorders or drops them.
- **Width rule:** operands pass through unmodified. Products are passed through bit-exact at `OUT_BITS`, with no rounding or saturation.
- **`busy`:** the OR of all tag-stage valid bits plus the output stage.
- **`arb_en` falling:** takes effect immediately for grants in the same cycle. In-flight results still complete.
- **Reset:** asserting `rst_n` low mid-operation immediately clears all tag valids. In-flight results are discarded, not emitted.

## Timing
- **Reset values:**
  - `req_ready`=0 while `rst_n` is low.
  - `mul_*`=0, `out_*`=0, `out_valid`=0, `busy`=0.
  - `last_grant`=`NUM_REQ-1`, so requester 0 has top priority first.
- **Latency:** a handshake in cycle n gives `out_valid` high in cycle n+`MULT_LATENCY`+1. With the default, that is cycle n+3.
- **Throughput:** one result per cycle sustained.
- **Fairness:** with all requesters continuously valid, grants cycle 0,1,2,3,0,…
  - A requester waits at most `NUM_REQ-1` cycles once its valid is asserted.
- **Operand stability:** a requester must hold its operands stable while `req_valid` is high and it is not yet granted.
- **Single requester:** if only requester k is valid, it is granted every cycle regardless of the pointer.

## Configuration
- **Macro:** `CPX_ARB_STATS_EN`.
- **Defined:** adds output `grant_count`, 32 bits.
  - Reset value 0.
  - Increments by 1 on every handshake.
  - Wraps from 0xFFFFFFFF to 0.
- **Undefined:** the port and the counter do not exist. All other behaviour is identical.

## Test plan
- **Reset state:** `rst_n` low, all `req_valid`=1 → `req_ready`=0, `out_valid`=0, `busy`=0. Release reset → the first grant is `req_ready`=4'b0001.
- **Single operation:** requester 2 issues x=(3,4), y=(5,−2) in cycle 0 → in cycle 3, `out_valid`=1, `out_id`=2, `out_i`=23, `out_q`=14. `busy` falls after that cycle.
- **Round-robin fairness:** all four requesters valid for 8 cycles → grant sequence 0,1,2,3,0,1,2,3. The results carry IDs in the same order, each 3 cycles after its grant.
- **Enable gating:** `arb_en` low in cycles 2–4 with requesters 0 and 1 valid → no grants in cycles 2–4. The two results issued in cycles 0 and 1 still appear in cycles 3 and 4. Granting resumes at requester 0.
- **Reset mid-flight:** `rst_n` is pulsed low one cycle after a handshake → no `out_valid` follows. Outputs read 0. With the macro defined, `grant_count` reads 0.
- **Extreme operands:** x=(−32768,−32768), y=(−32768,−32768) → `out_i`=0, `out_q`=2147483648, with the 33-bit result reproduced bit-exact.
